// File: rtl/xor_fault_monitor.sv
// xor_fault_monitor: sweeps the target XOR gate inputs through every pattern,
// samples the synchronised gate output after a settle delay and records any
// parity mismatch (laser-induced fault) for readout.
module xor_fault_monitor #(
  parameter int unsigned WIDTH         = 6,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             q_in,
  output logic [WIDTH-1:0] a_out,
  output logic             osc_en,
  output logic             busy,
  output logic             fault_pulse,
  output logic [CNT_W-1:0] fault_count,
  output logic [CNT_W-1:0] vec_count,
  output logic [WIDTH-1:0] last_fault_a,
  output logic             last_fault_q
);

  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_q_meta;
  logic               r_q_s;
  logic [SET_W-1:0]   r_settle;
  logic               r_stop_pend;
  logic [WIDTH-1:0]   r_a;
  logic               r_busy;
  logic               r_fault_pulse;
  logic [CNT_W-1:0]   r_fault_cnt;
  logic [CNT_W-1:0]   r_vec_cnt;
  logic [WIDTH-1:0]   r_lfa;
  logic               r_lfq;

  logic               w_settle_clr;
  logic               w_settle_inc;
  logic               w_do_sample;
  logic               w_do_clear;
  logic               w_mismatch;

  assign w_mismatch = r_q_s != (^r_a);

  // State register.
  always_ff @(posedge sysclk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic: a vector always completes; stop only decides what follows SAMPLE.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:   if (start && !stop) w_state_nxt = ST_DRIVE;
      ST_DRIVE:  if (r_settle == SETTLE_LAST) w_state_nxt = ST_SAMPLE;
      ST_SAMPLE: w_state_nxt = (r_stop_pend || stop) ? ST_IDLE : ST_DRIVE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Per-state control strobes.
  always_comb begin
    w_settle_clr = 1'b0;
    w_settle_inc = 1'b0;
    w_do_sample  = 1'b0;
    w_do_clear   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_settle_clr = 1'b1;
        w_do_clear   = clear;
      end
      ST_DRIVE:  w_settle_inc = (r_settle != SETTLE_LAST);
      ST_SAMPLE: begin
        w_do_sample  = 1'b1;
        w_settle_clr = 1'b1;
      end
      default: w_settle_clr = 1'b1;
    endcase
  end

  // Two-flop synchroniser for the asynchronous gate output.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_q_meta <= 1'b0;
      r_q_s    <= 1'b0;
    end else begin
      r_q_meta <= q_in;
      r_q_s    <= r_q_meta;
    end
  end

  // Settle counter, pending-stop flag and busy flag.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_settle    <= '0;
      r_stop_pend <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (w_settle_clr)      r_settle <= '0;
      else if (w_settle_inc) r_settle <= r_settle + SET_W'(1);
      r_stop_pend <= (w_state_nxt == ST_IDLE) ? 1'b0 : (r_stop_pend | stop);
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  // Pattern generator, counters and fault latches.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_a           <= '0;
      r_fault_pulse <= 1'b0;
      r_fault_cnt   <= '0;
      r_vec_cnt     <= '0;
      r_lfa         <= '0;
      r_lfq         <= 1'b0;
    end else begin
      r_fault_pulse <= w_do_sample & w_mismatch;
      if (w_do_clear) begin
        r_fault_cnt <= '0;
        r_vec_cnt   <= '0;
        r_lfa       <= '0;
        r_lfq       <= 1'b0;
      end else if (w_do_sample) begin
        r_vec_cnt <= r_vec_cnt + CNT_W'(1);
        r_a       <= r_a + WIDTH'(1);
        if (w_mismatch) begin
          if (r_fault_cnt != {CNT_W{1'b1}}) r_fault_cnt <= r_fault_cnt + CNT_W'(1);
          r_lfa <= r_a;
          r_lfq <= r_q_s;
        end
      end
    end
  end

  assign a_out        = r_a;
  assign osc_en       = 1'b0;
  assign busy         = r_busy;
  assign fault_pulse  = r_fault_pulse;
  assign fault_count  = r_fault_cnt;
  assign vec_count    = r_vec_cnt;
  assign last_fault_a = r_lfa;
  assign last_fault_q = r_lfq;

endmodule

// File: tb/tb_xor_fault_monitor.sv
// Bench for xor_fault_monitor: a gate model with a per-pattern fault mask
// drives q_in; a scoreboard of per-vector expectations is checked by a monitor.
module tb_xor_fault_monitor;

  logic        sysclk;
  logic        reset, start, stop, clear;
  logic        q_in, q_in2;
  logic [5:0]  a_out, a_out2;
  logic        osc_en, osc_en2, busy, busy2, fault_pulse, fault_pulse2;
  logic [15:0] fault_count, vec_count;
  logic [1:0]  fault_count2, vec_count2;
  logic [5:0]  last_fault_a, last_fault_a2;
  logic        last_fault_q, last_fault_q2;
  logic [63:0] inv_mask;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    int a_next; int mis; int fc; int vc; int lfa; int lfq; int fc2; int vc2;
  } exp_t;
  exp_t sb[$];

  int m_a, m_fc, m_vc, m_lfa, m_lfq, m_fc2, m_vc2;

  xor_fault_monitor #(.WIDTH(6), .SETTLE_CYCLES(4), .CNT_W(16)) dut (
    .sysclk(sysclk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .q_in(q_in), .a_out(a_out), .osc_en(osc_en), .busy(busy),
    .fault_pulse(fault_pulse), .fault_count(fault_count), .vec_count(vec_count),
    .last_fault_a(last_fault_a), .last_fault_q(last_fault_q));

  xor_fault_monitor #(.WIDTH(6), .SETTLE_CYCLES(4), .CNT_W(2)) dut2 (
    .sysclk(sysclk), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .q_in(q_in2), .a_out(a_out2), .osc_en(osc_en2), .busy(busy2),
    .fault_pulse(fault_pulse2), .fault_count(fault_count2), .vec_count(vec_count2),
    .last_fault_a(last_fault_a2), .last_fault_q(last_fault_q2));

  function automatic logic par6(input logic [5:0] a);
    return 1'($countones(a) % 2);
  endfunction

  // Target gate: ideal parity, inverted for patterns flagged in inv_mask.
  assign q_in  = par6(a_out)  ^ inv_mask[a_out];
  assign q_in2 = par6(a_out2) ^ inv_mask[a_out2];

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_a = 0; m_fc = 0; m_vc = 0; m_lfa = 0; m_lfq = 0; m_fc2 = 0; m_vc2 = 0;
  endtask

  task automatic model_clear();
    m_fc = 0; m_vc = 0; m_lfa = 0; m_lfq = 0; m_fc2 = 0; m_vc2 = 0;
  endtask

  // One vector: the gate answers with parity unless the mask inverts it.
  task automatic model_vector();
    exp_t e;
    int mis;
    mis = int'(inv_mask[m_a]);
    m_vc  = (m_vc + 1) % 65536;
    m_vc2 = (m_vc2 + 1) % 4;
    if (mis != 0) begin
      if (m_fc < 65535) m_fc++;
      if (m_fc2 < 3) m_fc2++;
      m_lfa = m_a;
      m_lfq = ($countones(m_a) % 2) ^ 1;
    end
    m_a = (m_a + 1) % 64;
    e.a_next = m_a; e.mis = mis; e.fc = m_fc; e.vc = m_vc;
    e.lfa = m_lfa; e.lfq = m_lfq; e.fc2 = m_fc2; e.vc2 = m_vc2;
    sb.push_back(e);
  endtask

  task automatic check_model_state(input string tag);
    chk({tag, "_a_out"}, int'(a_out), m_a);
    chk({tag, "_fc"}, int'(fault_count), m_fc);
    chk({tag, "_vc"}, int'(vec_count), m_vc);
    chk({tag, "_fc2"}, int'(fault_count2), m_fc2);
    chk({tag, "_vc2"}, int'(vec_count2), m_vc2);
  endtask

  // Run n vectors; stop pulses j cycles into the last vector; optional clear pulse.
  task automatic run(input int n, input int j, input int clr_at);
    int m;
    for (int i = 0; i < n; i++) model_vector();
    m = 5 * (n - 1) + j;
    @(negedge sysclk); start = 1'b1;
    @(negedge sysclk); start = 1'b0;
    chk("busy_rise", int'(busy), 1);
    for (int t = 0; t <= m; t++) begin
      stop  = (t == m);
      clear = (t == clr_at);
      @(negedge sysclk);
    end
    stop = 1'b0; clear = 1'b0;
    for (int w = 0; w < 12 && busy; w++) @(negedge sysclk);
    chk("busy_fall", int'(busy), 0);
    chk("sb_drained", sb.size(), 0);
    sb.delete();
    check_model_state("run");
  endtask

  task automatic do_clear();
    @(negedge sysclk); clear = 1'b1;
    @(negedge sysclk); clear = 1'b0;
    model_clear();
    chk("clr_fc", int'(fault_count), 0);
    chk("clr_vc", int'(vec_count), 0);
    chk("clr_lfa", int'(last_fault_a), 0);
    chk("clr_lfq", int'(last_fault_q), 0);
    chk("clr_fc2", int'(fault_count2), 0);
    chk("clr_vc2", int'(vec_count2), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_a_out"}, int'(a_out), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_pulse"}, int'(fault_pulse), 0);
    chk({tag, "_fc"}, int'(fault_count), 0);
    chk({tag, "_vc"}, int'(vec_count), 0);
    chk({tag, "_lfa"}, int'(last_fault_a), 0);
    chk({tag, "_lfq"}, int'(last_fault_q), 0);
    chk({tag, "_osc"}, int'(osc_en), 0);
  endtask

  // Monitor: a vec_count step marks a finished vector; pop and compare.
  initial begin : monitor
    logic [15:0] prev_vc;
    exp_t e;
    prev_vc = '0;
    forever begin
      @(posedge sysclk); #1;
      if (reset || clear) begin
        prev_vc = vec_count;
      end else if (vec_count != prev_vc) begin
        prev_vc = vec_count;
        if (sb.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL sb_underflow: vec_count %0d with no expected entry", vec_count);
        end else begin
          e = sb.pop_front();
          chk("mon_vc", int'(vec_count), e.vc);
          chk("mon_fc", int'(fault_count), e.fc);
          chk("mon_pulse", int'(fault_pulse), e.mis);
          chk("mon_a_next", int'(a_out), e.a_next);
          chk("mon_lfa", int'(last_fault_a), e.lfa);
          chk("mon_lfq", int'(last_fault_q), e.lfq);
          chk("mon_fc2", int'(fault_count2), e.fc2);
          chk("mon_vc2", int'(vec_count2), e.vc2);
        end
      end else begin
        chk("pulse_idle", int'(fault_pulse), 0);
      end
    end
  end

  initial begin : stim
    reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; inv_mask = '0;
    model_reset();
    repeat (3) @(negedge sysclk);
    reset = 1'b0;
    check_all_zero("rst");

    // Ideal gate, full sweep.
    run(64, int'($urandom_range(0, 4)), -1);
    chk("sweep_wrap_a", int'(a_out), 0);
    chk("sweep_vc", int'(vec_count), 64);

    // Single injected fault at 0x2A.
    inv_mask = 64'd1 << 42;
    run(64, int'($urandom_range(0, 4)), -1);
    chk("inj_fc", int'(fault_count), 1);
    chk("inj_lfa", int'(last_fault_a), 42);
    chk("inj_lfq", int'(last_fault_q), 0);

    // Stop one cycle into vector 5.
    inv_mask = '0;
    do_clear();
    run(6, 1, -1);
    chk("stop_vc", int'(vec_count), 6);

    // Narrow counters: saturation versus wrap.
    do_clear();
    inv_mask = '1;
    run(6, int'($urandom_range(0, 4)), -1);
    chk("sat_fc2", int'(fault_count2), 3);
    chk("wrap_vc2", int'(vec_count2), 2);
    chk("wide_fc", int'(fault_count), 6);

    // Clear while busy is ignored, clear in IDLE zeroes.
    inv_mask = {$urandom, $urandom};
    run(8, int'($urandom_range(0, 4)), 1);
    do_clear();

    // start together with stop stays IDLE.
    @(negedge sysclk); start = 1'b1; stop = 1'b1;
    @(negedge sysclk); start = 1'b0; stop = 1'b0;
    chk("ss_busy0", int'(busy), 0);
    @(negedge sysclk);
    chk("ss_busy1", int'(busy), 0);

    // Reset in the middle of DRIVE.
    @(negedge sysclk); start = 1'b1;
    @(negedge sysclk); start = 1'b0;
    repeat (2) @(negedge sysclk);
    reset = 1'b1;
    @(negedge sysclk); reset = 1'b0;
    sb.delete();
    model_reset();
    check_all_zero("midrst");
    inv_mask = {$urandom, $urandom};
    run(5, int'($urandom_range(0, 4)), -1);

    // Random runs.
    for (int r = 0; r < 6; r++) begin
      inv_mask = {$urandom, $urandom};
      run(int'($urandom_range(1, 12)), int'($urandom_range(0, 4)), -1);
    end

    repeat (3) @(negedge sysclk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
